// File: rtl/relu_maxpool_2x2_pkg.sv
// Shared network parameters for the ReLU + 2x2 max-pool stage.
// Optional feature macro: POOL_RELU_EN (clamp negative sums to zero).
package relu_maxpool_2x2_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FM_WIDTH   = 32;
    localparam int DEF_FM_HEIGHT  = 32;

`ifdef POOL_RELU_EN
    localparam bit ENABLE_RELU = 1'b1;
`else
    localparam bit ENABLE_RELU = 1'b0;
`endif

    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pool_bits(input int n);
        return cnt_bits(n / 2);
    endfunction

    localparam int POOL_X_BITWIDTH = pool_bits(DEF_FM_WIDTH);
    localparam int POOL_Y_BITWIDTH = pool_bits(DEF_FM_HEIGHT);

endpackage

// File: rtl/relu_maxpool_2x2_if.sv
// Pixel-in / pooled-pixel-out bundle between the adder tree and next layer.
// slave is the pooling stage, master is the producer/consumer side.
interface relu_maxpool_2x2_if #(
    parameter int DATA_WIDTH = 32,
    parameter int X_BITS     = 4,
    parameter int Y_BITS     = 4
);
    logic                         pixel_rdy;
    logic signed [DATA_WIDTH-1:0] pixel_in;
    logic                         pool_valid;
    logic signed [DATA_WIDTH-1:0] pool_out;
    logic [X_BITS-1:0]            pool_x;
    logic [Y_BITS-1:0]            pool_y;
    logic                         frame_done;

    modport slave (
        input  pixel_rdy, pixel_in,
        output pool_valid, pool_out, pool_x, pool_y, frame_done
    );

    modport master (
        output pixel_rdy, pixel_in,
        input  pool_valid, pool_out, pool_x, pool_y, frame_done
    );
endinterface

// File: rtl/relu_maxpool_2x2_pool_row_buffer.sv
// Half-row store of horizontal pair maxima from the even row of a window.
// One synchronous write port, one asynchronous read port; no reset needed.
module pool_row_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);
    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/relu_maxpool_2x2.sv
// Optional ReLU followed by 2x2 stride-2 max pooling on a raster stream.
// ReLU is compiled in when POOL_RELU_EN is defined.
module relu_maxpool_2x2
    import relu_maxpool_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FM_WIDTH   = DEF_FM_WIDTH,
    parameter int FM_HEIGHT  = DEF_FM_HEIGHT
) (
    input logic               clock,
    input logic               reset,
    input logic               start,
    relu_maxpool_2x2_if.slave bus
);
    localparam int CW = cnt_bits(FM_WIDTH);
    localparam int RW = cnt_bits(FM_HEIGHT);
    localparam int XW = pool_bits(FM_WIDTH);
    localparam int YW = pool_bits(FM_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(FM_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FM_HEIGHT - 1);

    if (FM_WIDTH < 2 || (FM_WIDTH % 2) != 0) begin : g_bad_width
        $error("FM_WIDTH must be even and >= 2");
    end
    if (FM_HEIGHT < 2 || (FM_HEIGHT % 2) != 0) begin : g_bad_height
        $error("FM_HEIGHT must be even and >= 2");
    end

    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic signed [DATA_WIDTH-1:0] hold;
    logic signed [DATA_WIDTH-1:0] val;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] above;
    logic signed [DATA_WIDTH-1:0] result;
    logic [XW-1:0]                cx;
    logic [YW-1:0]                ry;
    logic                         take;
    logic                         buf_we;
    logic                         emit;
    logic                         last;

    always_comb begin
        val = bus.pixel_in;
        if (ENABLE_RELU && bus.pixel_in < 0) begin
            val = '0;
        end
    end

    assign pair_max = (val > hold) ? val : hold;
    assign result   = (pair_max > above) ? pair_max : above;
    assign cx       = XW'(col >> 1);
    assign ry       = YW'(row >> 1);
    // start wins over a coincident pixel
    assign take     = bus.pixel_rdy && !start;
    assign buf_we   = take && col[0] && !row[0];
    assign emit     = take && col[0] && row[0];
    assign last     = (col == COL_LAST) && (row == ROW_LAST);

    pool_row_buffer #(
        .DEPTH      (FM_WIDTH / 2),
        .ADDR_WIDTH (XW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_row_buf (
        .clock   (clock),
        .wr_en   (buf_we),
        .wr_addr (cx),
        .wr_data (pair_max),
        .rd_addr (cx),
        .rd_data (above)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            hold <= '0;
        end else if (start) begin
            col <= '0;
            row <= '0;
            hold <= '0;
        end else if (bus.pixel_rdy) begin
            if (!col[0]) begin
                hold <= val;
            end
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.pool_valid <= 1'b0;
            bus.pool_out <= '0;
            bus.pool_x <= '0;
            bus.pool_y <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.pool_valid <= emit;
            bus.frame_done <= emit && last;
            if (emit) begin
                bus.pool_out <= result;
                bus.pool_x <= cx;
                bus.pool_y <= ry;
            end
        end
    end
endmodule
